// File: rtl/inst_fetch_pkg.sv
// Shared constants, types and helpers for the instruction fetch stage.
// Imported by inst_fifo and inst_fetch.
package inst_fetch_pkg;

    typedef logic [31:0] inst_t;
    typedef logic [31:0] pc_t;

    localparam inst_t NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0
    localparam pc_t   PC_STEP          = 32'd4;
    localparam pc_t   RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction fetches are always word aligned.
    function automatic pc_t align_pc(input pc_t pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous instruction buffer between the memory response port and DECODE.
// A pop in the same cycle frees the slot for a push, so push+pop while full is legal.
module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  inst_t         push_data,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output inst_t         head
);

    inst_t         mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; the count guards every read, so
    // stale contents are never observed and the array can map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// IF stage: owns fetch/deliver PCs, issues credit-limited word fetches, buffers
// responses for DECODE and discards responses belonging to a redirected stream.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter pc_t RESET_PC   = RESET_PC_DEFAULT,
    parameter int  FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

    pc_t           fetch_pc;
    pc_t           deliver_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          fifo_full;
    logic          fifo_empty;
    inst_t         fifo_head;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          pop;

    // Every fetch in flight or waiting in the buffer holds one credit.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

    // rst_n gates the request directly: while reset is held the credit state
    // reads as fully free, but nothing may be issued until reset is released.
    assign imem_req_valid = rst_n & ~redirect_valid & (credit_used < DEPTH_LIM);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response is stale if older than the last redirect, or arrives with one.
    assign rsp_drop = imem_rsp_valid & ((drop_cnt != '0) | redirect_valid);
    assign rsp_keep = imem_rsp_valid & ~rsp_drop;

    assign if_valid = ~fifo_empty & ~redirect_valid;
    assign if_inst  = fifo_empty ? NOP_INST : fifo_head;
    assign if_pc    = deliver_pc;
    assign pop      = if_valid & ~stall;

    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            deliver_pc  <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // No request fires in a redirect cycle, so everything still
                // outstanding after this edge belongs to the old stream.
                fetch_pc   <= align_pc(redirect_pc);
                deliver_pc <= align_pc(redirect_pc);
                drop_cnt   <= outstanding_nxt;
            end else begin
                if (req_fire) fetch_pc   <= fetch_pc + PC_STEP;
                if (pop)      deliver_pc <= deliver_pc + PC_STEP;
                if (rsp_drop) drop_cnt   <= drop_cnt - 1'b1;
            end
        end
    end

    inst_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data (imem_rsp_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Credit accounting guarantees neither of these can happen.
    a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outstanding != '0));
    a_no_overflow   : assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_keep && fifo_full && !pop));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: queued in-order memory model, delivery monitor,
// and immediate-assertion checks at fixed points of a linear stimulus sequence.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    int vectors = 0;
    int miscompares = 0;
    int mem_lat = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          cyc;
    logic [31:0] acc_addr[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_inst[$];
    logic [31:0] cap_pc;
    logic [31:0] cap_inst;

    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc)
    );

    // In-order memory: word at address a is 32'hA000_0000 | a, returned
    // mem_lat cycles after the accepting edge; cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            acc_addr.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
            cyc            <= 0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{addr: imem_req_addr, due: cyc + mem_lat - 1});
                acc_addr.push_back(imem_req_addr);
            end
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= 32'hA000_0000 | pend[0].addr;
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
            cyc <= cyc + 1;
        end
    end

    // Every instruction DECODE actually consumes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            del_pc.delete();
            del_inst.delete();
        end else if (if_valid && !stall) begin
            del_pc.push_back(if_pc);
            del_inst.push_back(if_inst);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Consumed stream must be base, base+4, ... with the matching memory word.
    task automatic check_stream(input string tag, input logic [31:0] base, input int min_len);
        check_bit({tag, "_len"}, del_pc.size() >= min_len, 1'b1);
        for (int i = 0; i < del_pc.size(); i++) begin
            check($sformatf("%s_pc%0d", tag, i), del_pc[i], base + 32'(4 * i));
            check($sformatf("%s_inst%0d", tag, i), del_inst[i],
                  32'hA000_0000 | (base + 32'(4 * i)));
        end
    endtask

    // Returns at the negedge that opens the first post-reset cycle.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_if_valid(input string tag);
        int n = 0;
        while (!if_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_bit(tag, if_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- 1: reset values, then free-running stream ----
        @(negedge clk);
        #1;
        check_bit("rst_req_valid", imem_req_valid, 1'b0);
        check_bit("rst_if_valid", if_valid, 1'b0);
        check("rst_if_inst", if_inst, 32'h0000_0013);
        check("rst_if_pc", if_pc, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_bit("t1_c0_req_valid", imem_req_valid, 1'b1);
        check("t1_c0_addr", imem_req_addr, 32'h0000_0000);
        check_bit("t1_c0_if_valid", if_valid, 1'b0);
        @(negedge clk);
        #1;
        check("t1_c1_addr", imem_req_addr, 32'h0000_0004);
        check_bit("t1_c1_if_valid", if_valid, 1'b0);
        @(negedge clk);
        #1;
        check_bit("t1_c2_if_valid", if_valid, 1'b1);
        check("t1_c2_if_pc", if_pc, 32'h0000_0000);
        check("t1_c2_if_inst", if_inst, 32'hA000_0000);
        check_bit("t1_c2_req_valid", imem_req_valid, 1'b0);
        @(negedge clk);
        #1;
        check("t1_c3_if_pc", if_pc, 32'h0000_0004);
        check("t1_c3_if_inst", if_inst, 32'hA000_0004);
        check("t1_c3_addr", imem_req_addr, 32'h0000_0008);
        repeat (20) @(negedge clk);
        #1;
        check_stream("t1", 32'h0, 8);

        // ---- 2: stall holds outputs, credit caps occupancy ----
        wait_if_valid("t2_valid_before_stall");
        stall = 1'b1;
        cap_pc = if_pc;
        cap_inst = if_inst;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("t2_hold_pc", if_pc, cap_pc);
            check("t2_hold_inst", if_inst, cap_inst);
            check_bit("t2_hold_valid", if_valid, 1'b1);
            check_bit("t2_credit", (acc_addr.size() - del_pc.size()) <= 2, 1'b1);
        end
        check_bit("t2_full_no_req", imem_req_valid, 1'b0);
        @(negedge clk);
        stall = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check_stream("t2", 32'h0, 16);

        // ---- 3: redirect with two fetches in flight ----
        mem_lat = 3;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0010;
        #1;
        check_bit("t3_c0_no_req", imem_req_valid, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("t3_c1_addr", imem_req_addr, 32'h0000_0010);
        @(negedge clk);
        #1;
        check("t3_c2_addr", imem_req_addr, 32'h0000_0014);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        check("t3_acc_count", 32'(acc_addr.size()), 32'd2);
        check("t3_acc0", acc_addr[0], 32'h0000_0010);
        check("t3_acc1", acc_addr[1], 32'h0000_0014);
        check_bit("t3_redir_no_req", imem_req_valid, 1'b0);
        check_bit("t3_redir_if_valid", if_valid, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("t3_c4_if_pc", if_pc, 32'h0000_0100);
        check_bit("t3_c4_no_credit", imem_req_valid, 1'b0);
        repeat (12) @(negedge clk);
        #1;
        check_stream("t3", 32'h0000_0100, 2);

        // ---- 4: request held while memory is not ready ----
        mem_lat = 1;
        imem_req_ready = 1'b0;
        do_reset();
        #1;
        repeat (3) begin
            check_bit("t4_hold_valid", imem_req_valid, 1'b1);
            check("t4_hold_addr", imem_req_addr, 32'h0000_0000);
            @(negedge clk);
            #1;
        end
        check("t4_none_accepted", 32'(acc_addr.size()), 32'd0);
        imem_req_ready = 1'b1;
        @(negedge clk);
        #1;
        check("t4_acc_count", 32'(acc_addr.size()), 32'd1);
        check("t4_acc0", acc_addr[0], 32'h0000_0000);
        check("t4_next_addr", imem_req_addr, 32'h0000_0004);

        // ---- 5: unaligned redirect + response + stall in one cycle ----
        do_reset();
        #1;
        check("t5_c0_addr", imem_req_addr, 32'h0000_0000);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        stall = 1'b1;
        #1;
        check_bit("t5_rsp_present", imem_rsp_valid, 1'b1);
        check_bit("t5_redir_no_req", imem_req_valid, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        stall = 1'b0;
        #1;
        check_bit("t5_if_valid", if_valid, 1'b0);
        check("t5_if_pc", if_pc, 32'h0000_0200);
        check("t5_addr", imem_req_addr, 32'h0000_0200);
        check_bit("t5_req_valid", imem_req_valid, 1'b1);
        repeat (8) @(negedge clk);
        #1;
        check_stream("t5", 32'h0000_0200, 2);

        // ---- 6: asynchronous reset in mid-stream ----
        do_reset();
        repeat (6) @(negedge clk);
        #1;
        wait_if_valid("t6_valid_before_rst");
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("t6_async_if_valid", if_valid, 1'b0);
        check_bit("t6_async_req_valid", imem_req_valid, 1'b0);
        check("t6_async_if_pc", if_pc, 32'h0000_0000);
        check("t6_async_if_inst", if_inst, 32'h0000_0013);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_bit("t6_c0_req_valid", imem_req_valid, 1'b1);
        check("t6_c0_addr", imem_req_addr, 32'h0000_0000);
        repeat (12) @(negedge clk);
        #1;
        check_stream("t6", 32'h0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
